atm_lookup_table: RTL and testbench
===================================

ATM_LOOKUP_TABLE -- requirements
Module: atm_lookup_table

Interface
REQ-001 SHALL have parameter ASIZE, default 8, address width; table depth 2**ASIZE entries.
REQ-002 SHALL have parameter DWIDTH, default 20, translation entry data width.
REQ-003 SHALL have parameter CWIDTH, default 16, miss counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports host_wren / host_rden / host_inval / host_flush  input  1 each  host write, read, invalidate-entry, flush-table strobes.
REQ-007 SHALL have port host_addr  input  ASIZE  host entry address.
REQ-008 SHALL have port host_wdata  input  DWIDTH  host write data.
REQ-009 SHALL have ports host_rdata  output  DWIDTH and host_rvalid  output  1  registered host read data and its 1-cycle valid pulse.
REQ-010 SHALL have port host_rhit  output  1  valid bit of the entry returned on host_rdata.
REQ-011 SHALL have port host_busy  output  1  high while a flush is in progress.
REQ-012 SHALL have ports fwd_rden  input  1 and fwd_addr  input  ASIZE  forwarding-path lookup request.
REQ-013 SHALL have ports fwd_rdata  output  DWIDTH, fwd_rvalid  output  1, fwd_hit  output  1  registered lookup result.
REQ-014 SHALL have port miss_cnt  output  CWIDTH  saturating count of fwd lookups returning fwd_hit=0.

Function
REQ-015 Each entry SHALL hold DWIDTH data plus one valid bit; only the valid bits and flush pointer need explicit clearing.
REQ-016 FSM SHALL have states FLUSH and IDLE; FLUSH clears valid[ptr] and data[ptr] to 0 each cycle, ptr increments, ptr==2**ASIZE-1 -> IDLE next cycle (flush takes exactly 2**ASIZE cycles).
REQ-017 host_flush in IDLE SHALL enter FLUSH with ptr=0 and clear miss_cnt the next edge; host_flush during FLUSH SHALL be ignored (no restart).
REQ-018 host_busy SHALL equal (state==FLUSH).
REQ-019 In IDLE, host_wren SHALL write host_wdata and set valid at host_addr; host_inval without host_wren SHALL clear valid only; host_wren with host_inval same cycle: write wins.
REQ-020 In FLUSH, host_wren and host_inval SHALL be dropped silently.
REQ-021 host_rden SHALL produce host_rvalid=1 exactly one cycle later with host_rdata/host_rhit of host_addr as sampled; accepted in both states (returns data 0, rhit 0 for already-cleared entries).
REQ-022 fwd_rden SHALL produce fwd_rvalid=1 exactly one cycle later; fwd_hit = valid bit, fwd_rdata = entry data if hit else 0; back-to-back requests every cycle SHALL be sustained.
REQ-023 During FLUSH every fwd lookup SHALL return fwd_hit=0, fwd_rdata=0 regardless of entry state.
REQ-024 Read-during-write (host or fwd read to address written/invalidated same cycle) SHALL return pre-write contents.
REQ-025 miss_cnt SHALL increment on each cycle fwd_rvalid=1 and fwd_hit=0, saturating at 2**CWIDTH-1; host_flush clear takes priority over increment.
REQ-026 host_rvalid and fwd_rvalid SHALL be 0 in cycles with no request one cycle prior.

Reset
REQ-027 rst_n low SHALL asynchronously force state=FLUSH, ptr=0, host_rdata=0, host_rvalid=0, host_rhit=0, fwd_rdata=0, fwd_rvalid=0, fwd_hit=0, miss_cnt=0; host_busy=1 while rst_n low.
REQ-028 After rst_n rises, a full 2**ASIZE-cycle flush SHALL run before host writes are accepted; reset mid-flush or mid-request SHALL abort all activity and restart the flush from ptr=0.

Verification
REQ-029 Reset release, ASIZE=8 -> host_busy=1 for exactly 256 cycles, then 0; fwd lookup of any address -> fwd_hit=0, fwd_rdata=0.
REQ-030 Host write addr 0x12 data 0xABCDE, next cycle fwd_rden addr 0x12 -> one cycle later fwd_rvalid=1, fwd_hit=1, fwd_rdata=0xABCDE; miss_cnt unchanged.
REQ-031 Same-cycle host_wren addr 0x40 data 0x11111 and fwd_rden addr 0x40 (entry previously 0x22222 valid) -> fwd_rdata=0x22222; following lookup -> 0x11111.
REQ-032 host_inval addr 0x12 then fwd lookup 0x12 -> fwd_hit=0, fwd_rdata=0, miss_cnt+1; simultaneous host_wren+host_inval -> entry valid with new data.
REQ-033 CWIDTH=4, 20 consecutive missing lookups -> miss_cnt stops at 15; host_flush -> miss_cnt=0, host_busy high 256 cycles, writes during flush have no effect.
REQ-034 rst_n pulsed low at flush ptr=100 -> outputs zero immediately, flush restarts, host_busy high 256 cycles after release.

Source files
------------

// File: rtl/atm_lookup_table.sv
// ---------------------------------------------------------------------------
// atm_lookup_table
//   Address-translation table for an ATM forwarding path. Each of the
//   2**ASIZE entries holds DWIDTH bits of data plus a valid bit. A host port
//   writes, invalidates and reads entries and can flush the whole table. A
//   separate forwarding port performs one lookup per cycle. Forwarding
//   lookups that miss are counted in a saturating counter.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   host_wren/_inval    write entry / clear entry valid bit (write wins)
//   host_rden           host read request; result one cycle later
//   host_flush          start a 2**ASIZE-cycle table flush (ignored if busy)
//   host_addr/_wdata    host entry address and write data
//   host_rdata/_rvalid/_rhit  registered host read result
//   host_busy           high while a flush is in progress
//   fwd_rden/_addr      forwarding lookup request
//   fwd_rdata/_rvalid/_hit    registered lookup result (data zero on a miss)
//   miss_cnt            saturating count of forwarding misses
// ---------------------------------------------------------------------------
module atm_lookup_table #(
    parameter int unsigned ASIZE  = 8,
    parameter int unsigned DWIDTH = 20,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_wren,
    input  logic              host_rden,
    input  logic              host_inval,
    input  logic              host_flush,
    input  logic [ASIZE-1:0]  host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              host_rhit,
    output logic              host_busy,
    input  logic              fwd_rden,
    input  logic [ASIZE-1:0]  fwd_addr,
    output logic [DWIDTH-1:0] fwd_rdata,
    output logic              fwd_rvalid,
    output logic              fwd_hit,
    output logic [CWIDTH-1:0] miss_cnt
);

    localparam int unsigned DEPTH = 2**ASIZE;

    typedef enum logic {
        FLUSH = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ASIZE-1:0]  ptr_q, ptr_d;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic [DWIDTH-1:0] host_rdata_q;
    logic              host_rvalid_q;
    logic              host_rhit_q;
    logic [DWIDTH-1:0] fwd_rdata_q;
    logic              fwd_rvalid_q;
    logic              fwd_hit_q;
    logic [CWIDTH-1:0] miss_q, miss_d;

    logic idle;
    logic wr_en;
    logic inv_en;
    logic flush_start;
    logic fwd_hit_d;

    assign idle        = (state_q == IDLE);
    assign wr_en       = idle && host_wren;
    assign inv_en      = idle && host_inval && !host_wren;
    assign flush_start = idle && host_flush;
    // Lookups during a flush always miss, whatever the entry still holds.
    assign fwd_hit_d   = idle && valid_q[fwd_addr];

    // ---------------- flush FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FLUSH;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            FLUSH: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = IDLE;
            end
            IDLE: begin
                if (host_flush) begin
                    state_d = FLUSH;
                    ptr_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // ---------------- table storage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (!idle) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (wr_en) begin
            valid_q[host_addr] <= 1'b1;
        end else if (inv_en) begin
            valid_q[host_addr] <= 1'b0;
        end
    end

    // Data needs no reset: every entry is zeroed by the flush that follows reset.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_en) begin
            mem_q[host_addr] <= host_wdata;
        end
    end

    // ---------------- miss counter ----------------
    always_comb begin
        miss_d = miss_q;
        if (flush_start) begin
            miss_d = '0;
        end else if (fwd_rvalid_q && !fwd_hit_q && (miss_q != '1)) begin
            miss_d = miss_q + 1'b1;
        end
    end

    // ---------------- registered read ports ----------------
    // Reads sample pre-edge contents, so a same-cycle write is not visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            host_rhit_q   <= 1'b0;
            fwd_rdata_q   <= '0;
            fwd_rvalid_q  <= 1'b0;
            fwd_hit_q     <= 1'b0;
            miss_q        <= '0;
        end else begin
            host_rvalid_q <= host_rden;
            if (host_rden) begin
                host_rdata_q <= mem_q[host_addr];
                host_rhit_q  <= valid_q[host_addr];
            end
            fwd_rvalid_q <= fwd_rden;
            if (fwd_rden) begin
                fwd_hit_q   <= fwd_hit_d;
                fwd_rdata_q <= fwd_hit_d ? mem_q[fwd_addr] : '0;
            end
            miss_q <= miss_d;
        end
    end

    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rhit   = host_rhit_q;
    assign host_busy   = (state_q == FLUSH);
    assign fwd_rdata   = fwd_rdata_q;
    assign fwd_rvalid  = fwd_rvalid_q;
    assign fwd_hit     = fwd_hit_q;
    assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_atm_lookup_table.sv
// ---------------------------------------------------------------------------
// tb_atm_lookup_table
//   Self-checking bench for atm_lookup_table (ASIZE=8, DWIDTH=20, CWIDTH=4).
//   A behavioural table model predicts every registered output; a compare
//   process checks the DUT against it on each falling edge. Directed
//   scenarios pin the model with literal expectations, then a randomized
//   phase exercises collisions on a small address range.
// ---------------------------------------------------------------------------
module tb_atm_lookup_table;

    localparam int MISS_MAX = 15;
    localparam int DEPTH    = 256;

    logic        clk;
    logic        rst_n;
    logic        host_wren, host_rden, host_inval, host_flush;
    logic [7:0]  host_addr;
    logic [19:0] host_wdata;
    logic [19:0] host_rdata;
    logic        host_rvalid, host_rhit, host_busy;
    logic        fwd_rden;
    logic [7:0]  fwd_addr;
    logic [19:0] fwd_rdata;
    logic        fwd_rvalid, fwd_hit;
    logic [3:0]  miss_cnt;

    int n_total = 0;
    int n_pass  = 0;

    atm_lookup_table #(.ASIZE(8), .DWIDTH(20), .CWIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_wren(host_wren), .host_rden(host_rden),
        .host_inval(host_inval), .host_flush(host_flush),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_rhit(host_rhit), .host_busy(host_busy),
        .fwd_rden(fwd_rden), .fwd_addr(fwd_addr),
        .fwd_rdata(fwd_rdata), .fwd_rvalid(fwd_rvalid),
        .fwd_hit(fwd_hit), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    logic [19:0] m_data [DEPTH];
    bit          m_valid [DEPTH];
    bit          m_busy = 1'b1;
    int          m_left = DEPTH;
    int          m_miss = 0;
    bit          e_hrv = 0, e_hhit = 0, e_frv = 0, e_fhit = 0;
    logic [19:0] e_hrd = '0, e_frd = '0;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b1; m_left = DEPTH; m_miss = 0;
            e_hrv = 0; e_hhit = 0; e_hrd = '0;
            e_frv = 0; e_fhit = 0; e_frd = '0;
            for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_data[i] = '0; end
        end else begin
            if (!m_busy && host_flush) m_miss = 0;
            else if (e_frv && !e_fhit && m_miss < MISS_MAX) m_miss++;
            e_hrv = host_rden;
            if (host_rden) begin
                e_hrd  = m_data[host_addr];
                e_hhit = m_valid[host_addr];
            end
            e_frv = fwd_rden;
            if (fwd_rden) begin
                e_fhit = !m_busy && m_valid[fwd_addr];
                e_frd  = e_fhit ? m_data[fwd_addr] : 20'h0;
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end else begin
                if (host_wren) begin
                    m_data[host_addr]  = host_wdata;
                    m_valid[host_addr] = 1'b1;
                end else if (host_inval) begin
                    m_valid[host_addr] = 1'b0;
                end
                // Net effect of a flush: every entry ends up zero and invalid.
                if (host_flush) begin
                    m_busy = 1'b1; m_left = DEPTH;
                    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_data[i] = '0; end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always begin
        @(negedge clk);
        chk("busy", {31'd0, host_busy}, {31'd0, m_busy});
        chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, e_hrv});
        if (e_hrv) begin
            chk("host_rdata", {12'd0, host_rdata}, {12'd0, e_hrd});
            chk("host_rhit", {31'd0, host_rhit}, {31'd0, e_hhit});
        end
        chk("fwd_rvalid", {31'd0, fwd_rvalid}, {31'd0, e_frv});
        if (e_frv) begin
            chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, e_fhit});
            chk("fwd_rdata", {12'd0, fwd_rdata}, {12'd0, e_frd});
        end
        chk("miss_cnt", {28'd0, miss_cnt}, m_miss);
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        host_wren = 0; host_rden = 0; host_inval = 0; host_flush = 0;
        fwd_rden = 0;
    endtask

    // Counts cycles with host_busy high, starting with the current one.
    // Optionally hammers host writes / fwd lookups while busy.
    task automatic count_busy(input bit do_wr, input bit do_fwd, output int n);
        n = 0;
        while (host_busy && n < 400) begin
            n++;
            if (do_wr) begin
                host_wren = 1; host_addr = 8'h12; host_wdata = 20'h55555;
            end
            if (do_fwd) begin
                fwd_rden = 1; fwd_addr = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    int          n;
    int          miss_before;
    logic [19:0] rnd;

    initial begin
        rst_n = 1'b0;
        host_addr = '0; host_wdata = '0; fwd_addr = '0;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, host_busy}, 32'd1);
        chk("reset_fwd_rvalid", {31'd0, fwd_rvalid}, 32'd0);
        chk("reset_miss", {28'd0, miss_cnt}, 32'd0);

        // Reset release: full flush, lookups of any address miss.
        rst_n = 1'b1;
        count_busy(1'b0, 1'b1, n);
        chk("reset_flush_len", n, 32'd256);

        // Fresh flush so the miss counter starts at zero.
        host_flush = 1; @(negedge clk); host_flush = 0;
        count_busy(1'b0, 1'b0, n);
        chk("flush_len_a", n, 32'd256);

        // Write then hit.
        host_wren = 1; host_addr = 8'h12; host_wdata = 20'hABCDE; @(negedge clk);
        clear_inputs(); fwd_rden = 1; fwd_addr = 8'h12; @(negedge clk);
        clear_inputs();
        chk("hit_rvalid", {31'd0, fwd_rvalid}, 32'd1);
        chk("hit_hit", {31'd0, fwd_hit}, 32'd1);
        chk("hit_data", {12'd0, fwd_rdata}, 32'h000ABCDE);
        @(negedge clk);
        chk("hit_miss_unchanged", {28'd0, miss_cnt}, 32'd0);
        chk("no_req_rvalid", {31'd0, fwd_rvalid}, 32'd0);

        // Read-during-write returns old contents.
        host_wren = 1; host_addr = 8'h40; host_wdata = 20'h22222; @(negedge clk);
        host_wdata = 20'h11111; fwd_rden = 1; fwd_addr = 8'h40; @(negedge clk);
        clear_inputs();
        chk("rdw_old_data", {12'd0, fwd_rdata}, 32'h00022222);
        fwd_rden = 1; @(negedge clk); clear_inputs();
        chk("rdw_new_data", {12'd0, fwd_rdata}, 32'h00011111);

        // Invalidate then miss; write+inval together keeps the write.
        host_inval = 1; host_addr = 8'h12; @(negedge clk);
        clear_inputs(); fwd_rden = 1; fwd_addr = 8'h12; @(negedge clk);
        clear_inputs();
        chk("inval_hit", {31'd0, fwd_hit}, 32'd0);
        chk("inval_data", {12'd0, fwd_rdata}, 32'd0);
        @(negedge clk);
        chk("inval_miss_inc", {28'd0, miss_cnt}, 32'd1);
        host_wren = 1; host_inval = 1; host_addr = 8'h12; host_wdata = 20'h33333; @(negedge clk);
        clear_inputs(); fwd_rden = 1; fwd_addr = 8'h12; host_rden = 1; @(negedge clk);
        clear_inputs();
        chk("wr_inval_hit", {31'd0, fwd_hit}, 32'd1);
        chk("wr_inval_data", {12'd0, fwd_rdata}, 32'h00033333);
        chk("host_rd_data", {12'd0, host_rdata}, 32'h00033333);
        chk("host_rd_hit", {31'd0, host_rhit}, 32'd1);

        // Miss counter saturation, then flush clears it and blocks writes.
        miss_before = int'(miss_cnt);
        fwd_rden = 1; fwd_addr = 8'h99;
        repeat (20) @(negedge clk);
        clear_inputs(); @(negedge clk); @(negedge clk);
        chk("miss_saturate", {28'd0, miss_cnt}, 32'd15);
        host_flush = 1; @(negedge clk); host_flush = 0;
        chk("flush_clears_miss", {28'd0, miss_cnt}, 32'd0);
        chk("flush_busy", {31'd0, host_busy}, 32'd1);
        count_busy(1'b1, 1'b0, n);
        chk("flush_len_b", n, 32'd256);
        fwd_rden = 1; fwd_addr = 8'h12; @(negedge clk); clear_inputs();
        chk("flush_write_dropped", {31'd0, fwd_hit}, 32'd0);
        chk("flush_write_data", {12'd0, fwd_rdata}, 32'd0);

        // Reset in the middle of a flush (ptr=100) with requests in flight.
        host_flush = 1; @(negedge clk); host_flush = 0;
        repeat (99) @(negedge clk);
        fwd_rden = 1; fwd_addr = 8'h05; host_rden = 1; host_addr = 8'h00;
        @(negedge clk);
        chk("pre_rst_fwd_rvalid", {31'd0, fwd_rvalid}, 32'd1);
        chk("pre_rst_host_rvalid", {31'd0, host_rvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_fwd_rvalid", {31'd0, fwd_rvalid}, 32'd0);
        chk("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("rst_busy", {31'd0, host_busy}, 32'd1);
        chk("rst_miss", {28'd0, miss_cnt}, 32'd0);
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy(1'b0, 1'b0, n);
        chk("rst_flush_len", n, 32'd256);

        // Randomized traffic on a small address range for collisions.
        for (int c = 0; c < 3000; c++) begin
            rnd        = 20'($urandom);
            host_wren  = ($urandom_range(0, 3) == 0);
            host_inval = ($urandom_range(0, 3) == 0);
            host_addr  = 8'($urandom_range(0, 15));
            host_wdata = rnd;
            host_rden  = !m_busy && ($urandom_range(0, 2) == 0);
            host_flush = ($urandom_range(0, 399) == 0);
            fwd_rden   = ($urandom_range(0, 1) == 0);
            fwd_addr   = 8'($urandom_range(0, 15));
            @(negedge clk);
        end
        clear_inputs();
        repeat (3) @(negedge clk);

        if (miss_before < 0) $display("unexpected miss count %0d", miss_before);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
